btn_debounce: RTL and testbench

Front-end conditioner for the board's active-low push-buttons. It turns a raw, bouncing, asynchronous button pin into a clean debounced level plus single-cycle press/release event pulses. Downstream edge-consuming logic (counters, LED steppers) can use press_o directly without its own edge detector. One instance per button, placed between the pad and the consuming block.

---
 rtl/btn_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 34 +++
 rtl/btn_debounce.sv | 165 ++++++++++++++++
 tb/tb_btn_debounce.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// ============================================================================
// Module  : btn_pkg
// Purpose : Shared types and defaults for the push-button debouncer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF      = 500000;
  localparam int unsigned REPEAT_DELAY_CYCLES_DEF  = 25000000;
  localparam int unsigned REPEAT_PERIOD_CYCLES_DEF = 5000000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchronizer for a single asynchronous input bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Purpose : Active-low button debouncer with level output and press/release
//           pulses; optional auto-repeat when BTN_AUTOREPEAT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DEF,
  parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_n_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned c_CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)) + 1;
  localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  logic w_btn_raw;
  logic w_btn_s;

  btn_state_e         r_state;
  btn_state_e         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_press_evt;
  logic               w_release_evt;
  logic               w_rpt_pulse;

  logic r_btn;
  logic r_press;
  logic r_release;

  assign w_btn_raw = ~btn_n_i;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_d     (w_btn_raw),
    .o_q     (w_btn_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_evt   = 1'b0;
    w_release_evt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_btn_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_press_evt = 1'b1;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = '0;
          w_release_evt = 1'b1;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [c_CNT_W-1:0] c_DLY_LAST = c_CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_PER_LAST = c_CNT_W'(REPEAT_PERIOD_CYCLES - 1);

  logic [c_CNT_W-1:0] r_rpt_cnt;
  logic               r_rpt_phase;
  logic               w_held;
  logic               w_rpt_hit;

  // Timer keeps running through RELEASE_WAIT bounces; an accepted release wins.
  assign w_held      = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
  assign w_rpt_hit   = (r_rpt_cnt == (r_rpt_phase ? c_PER_LAST : c_DLY_LAST));
  assign w_rpt_pulse = w_held && (w_state_nxt != RELEASED) && w_rpt_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
    end else if (!w_held || (w_state_nxt == RELEASED)) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
    end else if (w_rpt_hit) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b1;
    end else if (r_rpt_cnt != c_CNT_MAX) begin
      r_rpt_cnt <= r_rpt_cnt + c_ONE;
    end
  end
`else
  assign w_rpt_pulse = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_btn     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_btn     <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
      r_press   <= w_press_evt | w_rpt_pulse;
      r_release <= w_release_evt;
    end
  end

  assign btn_o     = r_btn;
  assign press_o   = r_press;
  assign release_o = r_release;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
// Module  : tb_btn_debounce
// Purpose : Scoreboard bench for btn_debounce (honours BTN_AUTOREPEAT_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;
  logic btn_n_i = 1'b1;
  logic btn_o, press_o, release_o;

  btn_debounce #(
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_DELAY_CYCLES  (DLY),
    .REPEAT_PERIOD_CYCLES (PER)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .btn_n_i   (btn_n_i),
    .btn_o     (btn_o),
    .press_o   (press_o),
    .release_o (release_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic btn;
    logic press;
    logic rel;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a level flips once the 2-cycle-delayed pin has disagreed
  // with it for DB+1 consecutive samples; repeats counted from acceptance.
  logic m_h1 = 1'b0, m_h2 = 1'b0, m_level = 1'b0;
  int   m_run = 0, m_held = 0;

  int edge_no = 0;
  int btn_hi  = 0;
  int press_log[$];
  int rel_log[$];

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic check_log(input string name, input int got[$], input int want[$]);
    check({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check($sformatf("%s_edge%0d", name, i), got[i], want[i]);
  endtask

  function automatic void model_push(input logic raw);
    exp_t e;
    logic s;
    s    = m_h2;
    m_h2 = m_h1;
    m_h1 = raw;
    e    = '0;
    if (s != m_level) m_run++;
    else              m_run = 0;
    if (m_run == DB + 1) begin
      m_level = s;
      m_run   = 0;
      m_held  = 0;
      if (s) e.press = 1'b1;
      else   e.rel   = 1'b1;
    end else if (m_level) begin
      m_held++;
`ifdef BTN_AUTOREPEAT_EN
      if (m_held >= DLY && ((m_held - DLY) % PER) == 0) e.press = 1'b1;
`endif
    end
    e.btn = m_level;
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic pin_n);
    @(negedge clk_i);
    btn_n_i = pin_n;
    model_push(~pin_n);
  endtask

  // Asserts reset, checks outputs drop at once, then releases reset and
  // drives the first post-reset cycle (edge 1) with pin_n.
  task automatic do_reset(input logic pin_n);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    btn_n_i = pin_n;
    #1;
    check("reset_outputs", {btn_o, press_o, release_o}, 0);
    exp_q.delete();
    m_h1 = 0; m_h2 = 0; m_level = 0; m_run = 0; m_held = 0;
    edge_no = 0; btn_hi = 0;
    press_log.delete();
    rel_log.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    model_push(~pin_n);
  endtask

  task automatic settle();
    @(posedge clk_i);
    #2;
  endtask

  // Monitor: pops one expectation per active clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_n_i) begin
        edge_no++;
        if (btn_o)     btn_hi++;
        if (press_o)   press_log.push_back(edge_no);
        if (release_o) rel_log.push_back(edge_no);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          if ({btn_o, press_o, release_o} !== e) begin
            n_bad++;
            $display("FAIL scoreboard edge %0d: got btn/press/rel=%b required %b",
                     edge_no, {btn_o, press_o, release_o}, e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int want[$];
    int lvl;
    int len;

    // Clean press: first pulse after edge DB+3.
    do_reset(1'b0);
    repeat (11) step(1'b0);
    settle();
    want = {DB + 3};
    check_log("clean_press", press_log, want);
    check("clean_press_no_release", rel_log.size(), 0);

    // Clean release: pin high from edge 13, release accepted at edge 19.
    repeat (12) step(1'b1);
    settle();
    want = {19};
    check_log("clean_release", rel_log, want);
`ifdef BTN_AUTOREPEAT_EN
    want = {DB + 3, DB + 3 + DLY};
`else
    want = {DB + 3};
`endif
    check_log("release_press", press_log, want);

    // Bounce: low 2, high 1, repeated; never stable long enough.
    do_reset(1'b0);
    for (int i = 1; i < 20; i++) step((i % 3) == 2);
    settle();
    check("bounce_press", press_log.size(), 0);
    check("bounce_release", rel_log.size(), 0);
    check("bounce_btn_high", btn_hi, 0);

    // Reset in PRESS_WAIT (cnt=2 after edge 5), then full latency again.
    do_reset(1'b0);
    repeat (4) step(1'b0);
    do_reset(1'b0);
    repeat (9) step(1'b0);
    settle();
    want = {DB + 3};
    check_log("reset_mid_debounce", press_log, want);

    // Long hold: auto-repeat pulses (if built) after the first press.
    do_reset(1'b0);
    repeat (39) step(1'b0);
    settle();
    want = {DB + 3};
`ifdef BTN_AUTOREPEAT_EN
    for (int k = DB + 3 + DLY; k <= 40; k += PER) want.push_back(k);
`endif
    check_log("hold", press_log, want);

    // Randomized runs (includes reset mid-hold, checked for immediate drop).
    do_reset(1'b1);
    for (int n = 0; n < 300; n++) begin
      lvl = $urandom_range(0, 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 25) : $urandom_range(1, 6);
      if ($urandom_range(0, 49) == 0) do_reset(lvl[0]);
      for (int j = 0; j < len; j++) step(lvl[0]);
    end
    settle();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
